apb_master: RTL

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master_if.sv | 37 +++
 rtl/apb_master.sv | 96 +++++++++
 2 files changed

// File: rtl/apb_master_if.sv
// APB master bus bundle: command/response handshake plus APB pins.
// master modport is the bridge's view; slave is the requester/peripheral side.
interface apb_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_slverr;
   logic              psel;
   logic              pen;
   logic              pwrite;
   logic [ADDR_W-1:0] paddr;
   logic [DATA_W-1:0] pwdata;
   logic              pready;
   logic [DATA_W-1:0] prdata;
   logic              pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  pready, prdata, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
      output psel, pen, pwrite, paddr, pwdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output pready, prdata, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
      input  psel, pen, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// Command-to-APB bridge: IDLE/SETUP/ACCESS with fully registered outputs.
// Optional ACCESS watchdog enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input logic        pclk,
   input logic        prst,
   apb_master_if.master bus
);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_t;

   state_t state;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;
`endif

   // Transfer sequencer; every bus and response output is a register here.
   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         state          <= IDLE;
         bus.cmd_ready  <= 1'b1;
         bus.psel       <= 1'b0;
         bus.pen        <= 1'b0;
         bus.pwrite     <= 1'b0;
         bus.paddr      <= '0;
         bus.pwdata     <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_rdata  <= '0;
         bus.rsp_slverr <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt            <= '0;
`endif
      end else begin
         bus.rsp_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  state         <= SETUP;
                  bus.cmd_ready <= 1'b0;
                  bus.psel      <= 1'b1;
                  bus.pen       <= 1'b0;
                  bus.pwrite    <= bus.cmd_write;
                  bus.paddr     <= bus.cmd_addr;
                  bus.pwdata    <= bus.cmd_write ? bus.cmd_wdata
                                                 : {DATA_W{1'b0}};
`ifdef APB_MASTER_TIMEOUT_EN
                  cnt           <= '0;
`endif
               end
            end
            SETUP: begin
               state   <= ACCESS;
               bus.pen <= 1'b1;
            end
            ACCESS: begin
               if (bus.pready) begin
                  state          <= IDLE;
                  bus.psel       <= 1'b0;
                  bus.pen        <= 1'b0;
                  bus.cmd_ready  <= 1'b1;
                  bus.rsp_valid  <= 1'b1;
                  bus.rsp_rdata  <= bus.pwrite ? {DATA_W{1'b0}}
                                               : bus.prdata;
                  bus.rsp_slverr <= bus.pslverr;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
                  state          <= IDLE;
                  bus.psel       <= 1'b0;
                  bus.pen        <= 1'b0;
                  bus.cmd_ready  <= 1'b1;
                  bus.rsp_valid  <= 1'b1;
                  bus.rsp_rdata  <= '0;
                  bus.rsp_slverr <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
